uart_byte_rx: RTL and testbench

- Standalone UART receiver, 8N1, LSB first, idle-high line.
- Receiving end of the link the echo path transmits on. Recovers bytes from an asynchronous serial input and presents each one with a single-cycle valid strobe.
- Includes input synchronisation, start-bit validation, 3-sample majority voting and framing-error detection.
- Used as the RX front end feeding the echo/command logic at 50 MHz, 115200 baud.

---
 rtl/uart_byte_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver, LSB first, idle-high line.
// A two-flop synchroniser feeds an edge detector and a mid-bit sampler.
// Each bit is sampled three times around its centre and decided by majority.
// A framed byte is presented on rx_data with a one-cycle rx_done strobe.
// A low stop bit raises a one-cycle frame_err and leaves rx_data untouched.
module uart_byte_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  // Clocks per bit, rounded to nearest (434 at 50 MHz / 115200).
  localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  // Nominal centre of a bit, measured from the start-detect clear.
  localparam int MID      = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SAMP_A = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_SAMP_B = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_SAMP_C = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(MID + 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             sync_1;
  logic             rxd_s;
  logic             rxd_d;

  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       samples;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  logic             start_edge;
  logic             counting;
  logic             sample_en;
  logic             decide;
  logic             vote;

  logic             cnt_clear;
  logic             shift_en;
  logic             load_data;
  logic             err_next;

  // Two-flop synchroniser plus a delay flop for falling-edge detection.
  // Reset to 1 so the release of reset never looks like a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_1 <= 1'b1;
      rxd_s  <= 1'b1;
      rxd_d  <= 1'b1;
    end else begin
      sync_1 <= rxd;
      rxd_s  <= sync_1;
      rxd_d  <= rxd_s;
    end
  end

  // Qualifiers derived from the counter and the synchronised line.
  always_comb begin
    start_edge = rxd_d & ~rxd_s;
    counting   = (state == START) || (state == DATA) || (state == STOP);
    sample_en  = counting &&
                 ((baud_cnt == CNT_SAMP_A) ||
                  (baud_cnt == CNT_SAMP_B) ||
                  (baud_cnt == CNT_SAMP_C));
    decide     = counting && (baud_cnt == CNT_DECIDE);
    vote       = (samples[0] & samples[1]) |
                 (samples[0] & samples[2]) |
                 (samples[1] & samples[2]);
  end

  // Baud counter: free-runs 0..BAUD_DIV-1 while a frame is in progress,
  // cleared on start detect and parked at zero otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_cnt <= '0;
    end else if (cnt_clear) begin
      baud_cnt <= '0;
    end else if (counting) begin
      if (baud_cnt == CNT_LAST) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end else begin
      baud_cnt <= '0;
    end
  end

  // Capture the three samples straddling the bit centre for the vote.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      samples <= 3'b111;
    end else if (sample_en) begin
      samples <= {samples[1:0], rxd_s};
    end
  end

  // Data bit index: held at zero through the start bit, advanced per data bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_idx <= '0;
    end else if (state == START) begin
      bit_idx <= '0;
    end else if (shift_en) begin
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // Shift register fills from the top so the first (LSB) bit ends at bit 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {vote, shift_reg[7:1]};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath controls; all decisions act on the voted bit.
  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    shift_en   = 1'b0;
    load_data  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_next = START;
          cnt_clear  = 1'b1;
        end
      end
      START: begin
        if (decide) begin
          if (!vote) begin
            state_next = DATA;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (decide) begin
          if (vote) begin
            load_data  = 1'b1;
            state_next = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered outputs: the byte and its strobe update on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= load_data;
      frame_err <= err_next;
      if (load_data) begin
        rx_data <= shift_reg;
      end
    end
  end

  assign rx_busy = (state != IDLE);

  // Strobes are mutually exclusive and never longer than one cycle.
  a_strobe_exclusive: assert property (@(posedge clk) disable iff (!rstn)
    !(rx_done && frame_err));
  a_done_single: assert property (@(posedge clk) disable iff (!rstn)
    rx_done |=> !rx_done);
  a_err_single: assert property (@(posedge clk) disable iff (!rstn)
    frame_err |=> !frame_err);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: drives serial frames at chosen bit periods and compares
// the received bytes and status strobes with a simple intended-byte model.
module tb_uart_byte_rx;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int CLK_NS = 20;
  localparam int BIT_NS = 8680;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int assertions_evaluated = 0;
  int failures             = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  time        done_times[$];
  logic [7:0] last_good = 8'h00;
  time        t_start   = 0;

  int   done_cnt   = 0;
  int   err_cnt    = 0;
  int   busy_falls = 0;
  logic both_seen  = 1'b0;
  logic data_glitch = 1'b0;
  logic prev_busy  = 1'b0;
  logic prev_rstn  = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_byte_rx dut (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  // 50 MHz clock.
  always #(CLK_NS / 2) clk = ~clk;

  // Observe strobes on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rx_done) begin
      rx_log.push_back(rx_data);
      done_times.push_back($time);
      done_cnt = done_cnt + 1;
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (rx_done && frame_err) both_seen = 1'b1;
    if (prev_busy && !rx_busy) busy_falls = busy_falls + 1;
    if (rstn && prev_rstn && !rx_done && (rx_data !== prev_data)) data_glitch = 1'b1;
    prev_busy = rx_busy;
    prev_data = rx_data;
    prev_rstn = rstn;
  end

  // Bound the whole run.
  initial begin
    #4ms;
    $display("[TB] FAIL watchdog: observed run still active, expected end before 4 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions_evaluated = assertions_evaluated + 1;
    if (observed !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Serialise one 8N1 frame; the line is left at the stop level.
  task automatic applyStimulus(input logic [7:0] data, input int bit_ns,
                               input logic stop_val);
    rxd     = 1'b0;
    t_start = $time;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      #(bit_ns);
    end
    rxd = stop_val;
    #(bit_ns);
  endtask

  // Compare everything received since the last call with the intended bytes.
  task automatic checkReceived(input string tag);
    checkOutput({tag, " count"}, 32'(rx_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_log.size())
        checkOutput($sformatf("%s byte%0d", tag, i), 32'(rx_log[i]), 32'(exp_q[i]));
    end
    if (exp_q.size() > 0) last_good = exp_q[exp_q.size() - 1];
    @(negedge clk);
    checkOutput({tag, " held data"}, 32'(rx_data), 32'(last_good));
    rx_log.delete();
    exp_q.delete();
    done_times.delete();
  endtask

  initial begin
    int done_snap;
    int err_snap;
    int falls_snap;
    int lat;
    logic [7:0] rb;
    int per;
    int gap;

    $display("[TB] start");

    // Reset values.
    #5;
    @(negedge clk);
    checkOutput("reset rx_data", 32'(rx_data), 32'h00);
    checkOutput("reset rx_done", 32'(rx_done), 32'h0);
    checkOutput("reset frame_err", 32'(frame_err), 32'h0);
    checkOutput("reset rx_busy", 32'(rx_busy), 32'h0);
    #100;
    rstn = 1'b1;
    #200;

    // Single byte with latency measurement.
    #20;
    exp_q.push_back(8'h22);
    applyStimulus(8'h22, BIT_NS, 1'b1);
    #2000;
    if (done_times.size() > 0) begin
      lat = int'((done_times[0] - t_start + 9 * BIT_NS) / CLK_NS) - 9 * (BIT_NS / CLK_NS);
      lat = int'((done_times[0] - (t_start - 0)) / CLK_NS);
      checkOutput($sformatf("latency %0d clk", lat), 32'(lat >= 4118 && lat <= 4134), 32'h1);
    end else begin
      checkOutput("latency no rx_done", 32'h0, 32'h1);
    end
    checkOutput("byte22 frame_err count", 32'(err_cnt), 32'h0);
    checkReceived("byte22");

    // Back-to-back frames, single stop bit between them.
    falls_snap = busy_falls;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h34);
    applyStimulus(8'h11, BIT_NS, 1'b1);
    applyStimulus(8'h33, BIT_NS, 1'b1);
    applyStimulus(8'h34, BIT_NS, 1'b1);
    #2000;
    checkOutput("b2b busy drops", 32'(busy_falls - falls_snap), 32'h3);
    checkReceived("b2b");

    // Short low glitch is rejected at the start-bit vote.
    done_snap = done_cnt;
    err_snap  = err_cnt;
    rxd = 1'b0;
    #1000;
    rxd = 1'b1;
    #4000;
    @(negedge clk);
    checkOutput("glitch busy", 32'(rx_busy), 32'h0);
    checkOutput("glitch rx_done", 32'(done_cnt - done_snap), 32'h0);
    checkOutput("glitch frame_err", 32'(err_cnt - err_snap), 32'h0);
    #2000;
    exp_q.push_back(8'h5A);
    applyStimulus(8'h5A, BIT_NS, 1'b1);
    #2000;
    checkReceived("after glitch");

    // Low stop bit, then a stuck-low line.
    done_snap = done_cnt;
    err_snap  = err_cnt;
    applyStimulus(8'hA5, BIT_NS, 1'b0);
    #50000;
    @(negedge clk);
    checkOutput("ferr pulse count", 32'(err_cnt - err_snap), 32'h1);
    checkOutput("ferr no rx_done", 32'(done_cnt - done_snap), 32'h0);
    checkOutput("ferr busy while low", 32'(rx_busy), 32'h1);
    checkOutput("ferr data kept", 32'(rx_data), 32'(last_good));
    rxd = 1'b1;
    #2000;
    @(negedge clk);
    checkOutput("ferr busy after rise", 32'(rx_busy), 32'h0);
    exp_q.push_back(8'hC3);
    applyStimulus(8'hC3, BIT_NS, 1'b1);
    #2000;
    checkReceived("after ferr");

    // Reset during bit 4 aborts the frame.
    fork
      applyStimulus(8'hFF, BIT_NS, 1'b1);
      begin
        #(4 * BIT_NS + BIT_NS / 2);
        rstn = 1'b0;
        #15;
        checkOutput("midreset rx_data", 32'(rx_data), 32'h00);
        checkOutput("midreset rx_done", 32'(rx_done), 32'h0);
        checkOutput("midreset frame_err", 32'(frame_err), 32'h0);
        checkOutput("midreset rx_busy", 32'(rx_busy), 32'h0);
        #100;
        rstn = 1'b1;
      end
    join
    last_good = 8'h00;
    #2000;
    checkReceived("aborted frame");
    exp_q.push_back(8'h81);
    applyStimulus(8'h81, BIT_NS, 1'b1);
    #2000;
    checkReceived("after reset");

    // Transmitter bit period at +3% and -3%.
    err_snap = err_cnt;
    exp_q.push_back(8'hA5);
    applyStimulus(8'hA5, 8940, 1'b1);
    #2000;
    checkReceived("slow tx");
    exp_q.push_back(8'hA5);
    applyStimulus(8'hA5, 8420, 1'b1);
    #2000;
    checkReceived("fast tx");
    checkOutput("tolerance frame_err", 32'(err_cnt - err_snap), 32'h0);

    // Random bytes, periods and idle gaps.
    err_snap = err_cnt;
    for (int n = 0; n < 3; n++) begin
      rb  = 8'($urandom);
      per = int'($urandom_range(8910, 8450));
      gap = int'($urandom_range(2000, 0));
      #(gap);
      exp_q.push_back(rb);
      applyStimulus(rb, per, 1'b1);
    end
    #2000;
    checkReceived("random");
    checkOutput("random frame_err", 32'(err_cnt - err_snap), 32'h0);

    // Whole-run properties.
    checkOutput("done/err exclusive", 32'(both_seen), 32'h0);
    checkOutput("rx_data only moves with rx_done", 32'(data_glitch), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions_evaluated, failures);
    $finish;
  end

endmodule
